// File: rtl/fifo_ecc_err_mon.sv
// fifo_ecc_err_mon
// ------------------------------------------------------------------
// Monitors the per-lane ECC status of the FIFO lane chain (K lanes).
// For every lane it keeps saturating single-bit and double-bit error
// counters. It also keeps sticky summary flags, a saturating count of
// chain data-mismatch pulses, the index of the first lane to report a
// double-bit error, and a registered alarm. A request/ack read port
// returns one lane's counters at a time for slow-control readout.
//
// Optional build macro: FIFO_ECC_ERR_MON_TIMESTAMP_EN
//   When defined, a free-running 32-bit cycle counter is added, and
//   first_dbit_ts_o records the counter value at the first double-bit
//   error.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   sbiterr_i[K]       per-lane single-bit-corrected pulses
//   dbiterr_i[K]       per-lane double-bit-detected pulses
//   err_i              chain data-mismatch pulse
//   clr_i              clears counters, stickies, capture and alarm
//   rd_req_i/rd_lane_i read request and lane index
//   rd_ack_o           read data valid, 2 cycles after rd_req_i
//   rd_sbit_cnt_o      single-bit count of the read lane
//   rd_dbit_cnt_o      double-bit count of the read lane
//   rd_oor_o           read lane index was >= K
//   sbit_any_o         sticky: a single-bit error was seen on some lane
//   dbit_any_o         sticky: a double-bit error was seen on some lane
//   err_cnt_o          saturating count of err_i pulses
//   first_dbit_vld_o   first double-bit lane has been captured
//   first_dbit_lane_o  index of that lane
//   first_dbit_ts_o    (optional) cycle stamp of that capture
//   alarm_o            registered alarm
// ------------------------------------------------------------------

// Per-lane pair of saturating error counters.
module fifo_ecc_err_mon_lane #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             sbit_i,
    input  logic             dbit_i,
    output logic [CNT_W-1:0] sbit_cnt,
    output logic [CNT_W-1:0] dbit_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sbit_cnt <= '0;
            dbit_cnt <= '0;
        end else begin
            if (sbit_i && sbit_cnt != CNT_MAX) sbit_cnt <= sbit_cnt + CNT_W'(1);
            if (dbit_i && dbit_cnt != CNT_MAX) dbit_cnt <= dbit_cnt + CNT_W'(1);
        end
    end
endmodule

module fifo_ecc_err_mon #(
    parameter int K        = 48,
    parameter int CNT_W    = 16,
    parameter int SBIT_THR = 100,
    parameter int LW       = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [K-1:0]     sbiterr_i,
    input  logic [K-1:0]     dbiterr_i,
    input  logic             err_i,
    input  logic             clr_i,
    input  logic             rd_req_i,
    input  logic [LW-1:0]    rd_lane_i,
    output logic             rd_ack_o,
    output logic [CNT_W-1:0] rd_sbit_cnt_o,
    output logic [CNT_W-1:0] rd_dbit_cnt_o,
    output logic             rd_oor_o,
    output logic             sbit_any_o,
    output logic             dbit_any_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             first_dbit_vld_o,
    output logic [LW-1:0]    first_dbit_lane_o,
`ifdef FIFO_ECC_ERR_MON_TIMESTAMP_EN
    output logic [31:0]      first_dbit_ts_o,
`endif
    output logic             alarm_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, RESP} rd_state_t;

    typedef struct packed {
        logic [CNT_W-1:0] sbit;
        logic [CNT_W-1:0] dbit;
        logic             oor;
    } rd_rsp_t;

    logic [K-1:0][CNT_W-1:0] sbit_cnt;
    logic [K-1:0][CNT_W-1:0] dbit_cnt;
    logic [K-1:0]            thr_hit;

    // ---------------- per-lane counters ----------------
    for (genvar g = 0; g < K; g++) begin : g_lane
        fifo_ecc_err_mon_lane #(.CNT_W(CNT_W)) u_lane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clr_i    (clr_i),
            .sbit_i   (sbiterr_i[g]),
            .dbit_i   (dbiterr_i[g]),
            .sbit_cnt (sbit_cnt[g]),
            .dbit_cnt (dbit_cnt[g])
        );
        assign thr_hit[g] = (sbit_cnt[g] >= CNT_W'(SBIT_THR));
    end

    // Lowest set dbiterr_i index: scan downwards so the lowest hit wins.
    logic [LW-1:0] first_idx;
    always_comb begin
        first_idx = '0;
        for (int i = K - 1; i >= 0; i--)
            if (dbiterr_i[i]) first_idx = LW'(i);
    end

`ifdef FIFO_ECC_ERR_MON_TIMESTAMP_EN
    // Free-running stamp; deliberately untouched by clr_i.
    logic [31:0] cyc_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) cyc_cnt <= '0;
        else       cyc_cnt <= cyc_cnt + 32'd1;
    end
`endif

    // ---------------- summary state ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            err_cnt_o         <= '0;
            sbit_any_o        <= 1'b0;
            dbit_any_o        <= 1'b0;
            first_dbit_vld_o  <= 1'b0;
            first_dbit_lane_o <= '0;
`ifdef FIFO_ECC_ERR_MON_TIMESTAMP_EN
            first_dbit_ts_o   <= '0;
`endif
            alarm_o           <= 1'b0;
        end else begin
            if (err_i && err_cnt_o != CNT_MAX) err_cnt_o <= err_cnt_o + CNT_W'(1);
            sbit_any_o <= sbit_any_o | (|sbiterr_i);
            dbit_any_o <= dbit_any_o | (|dbiterr_i);
            if (!first_dbit_vld_o && (|dbiterr_i)) begin
                first_dbit_vld_o  <= 1'b1;
                first_dbit_lane_o <= first_idx;
`ifdef FIFO_ECC_ERR_MON_TIMESTAMP_EN
                first_dbit_ts_o   <= cyc_cnt;
`endif
            end
            // Built from registered state, hence one cycle behind it.
            alarm_o <= dbit_any_o | (|thr_hit) | (err_cnt_o != '0);
        end
    end

    // ---------------- read port ----------------
    rd_rsp_t lane_sel;
    always_comb begin
        lane_sel     = '0;
        lane_sel.oor = 1'b1;
        for (int i = 0; i < K; i++) begin
            if (rd_lane_i == LW'(i)) begin
                lane_sel.sbit = sbit_cnt[i];
                lane_sel.dbit = dbit_cnt[i];
                lane_sel.oor  = 1'b0;
            end
        end
    end

    rd_state_t rd_state;
    rd_rsp_t   rd_snap;

    // The snapshot is taken on the RESP-entry edge, before that edge's
    // increment lands. A same-edge clr_i zeroes the counts, matching
    // what the counters themselves become.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state      <= IDLE;
            rd_snap       <= '0;
            rd_ack_o      <= 1'b0;
            rd_sbit_cnt_o <= '0;
            rd_dbit_cnt_o <= '0;
            rd_oor_o      <= 1'b0;
        end else begin
            rd_ack_o <= 1'b0;
            case (rd_state)
                IDLE: begin
                    if (rd_req_i) begin
                        rd_snap.sbit <= clr_i ? '0 : lane_sel.sbit;
                        rd_snap.dbit <= clr_i ? '0 : lane_sel.dbit;
                        rd_snap.oor  <= lane_sel.oor;
                        rd_state     <= RESP;
                    end
                end
                RESP: begin
                    rd_sbit_cnt_o <= rd_snap.sbit;
                    rd_dbit_cnt_o <= rd_snap.dbit;
                    rd_oor_o      <= rd_snap.oor;
                    rd_ack_o      <= 1'b1;
                    rd_state      <= IDLE;
                end
                default: rd_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_ecc_err_mon.sv
module tb_fifo_ecc_err_mon;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [47:0] sbiterr_i = '0, dbiterr_i = '0;
    logic        err_i = 1'b0, clr_i = 1'b0, rd_req_i = 1'b0;
    logic [6:0]  rd_lane_i = '0;
    logic        rd_ack_o, rd_oor_o, sbit_any_o, dbit_any_o, first_dbit_vld_o, alarm_o;
    logic [15:0] rd_sbit_cnt_o, rd_dbit_cnt_o, err_cnt_o;
    logic [6:0]  first_dbit_lane_o;
`ifdef FIFO_ECC_ERR_MON_TIMESTAMP_EN
    logic [31:0] first_dbit_ts_o;
`endif

    // narrow-counter instance for the saturation check
    logic [47:0] sbiterr_s = '0;
    logic        rd_req_s = 1'b0;
    logic [6:0]  rd_lane_s = '0;
    logic        ack_s, oor_s, sany_s, dany_s, fvld_s, alarm_s;
    logic [3:0]  scnt_s, dcnt_s, ecnt_s;
    logic [6:0]  flane_s;
`ifdef FIFO_ECC_ERR_MON_TIMESTAMP_EN
    logic [31:0] ts_s;
`endif

    always #5 clk = ~clk;

    fifo_ecc_err_mon #(.K(48), .CNT_W(16), .SBIT_THR(100), .LW(7)) dut (
        .clk_i(clk), .rst_i(rst_i), .sbiterr_i(sbiterr_i), .dbiterr_i(dbiterr_i),
        .err_i(err_i), .clr_i(clr_i), .rd_req_i(rd_req_i), .rd_lane_i(rd_lane_i),
        .rd_ack_o(rd_ack_o), .rd_sbit_cnt_o(rd_sbit_cnt_o), .rd_dbit_cnt_o(rd_dbit_cnt_o),
        .rd_oor_o(rd_oor_o), .sbit_any_o(sbit_any_o), .dbit_any_o(dbit_any_o),
        .err_cnt_o(err_cnt_o), .first_dbit_vld_o(first_dbit_vld_o),
        .first_dbit_lane_o(first_dbit_lane_o),
`ifdef FIFO_ECC_ERR_MON_TIMESTAMP_EN
        .first_dbit_ts_o(first_dbit_ts_o),
`endif
        .alarm_o(alarm_o));

    fifo_ecc_err_mon #(.K(48), .CNT_W(4), .SBIT_THR(10), .LW(7)) dut_s (
        .clk_i(clk), .rst_i(rst_i), .sbiterr_i(sbiterr_s), .dbiterr_i(48'd0),
        .err_i(1'b0), .clr_i(1'b0), .rd_req_i(rd_req_s), .rd_lane_i(rd_lane_s),
        .rd_ack_o(ack_s), .rd_sbit_cnt_o(scnt_s), .rd_dbit_cnt_o(dcnt_s),
        .rd_oor_o(oor_s), .sbit_any_o(sany_s), .dbit_any_o(dany_s),
        .err_cnt_o(ecnt_s), .first_dbit_vld_o(fvld_s), .first_dbit_lane_o(flane_s),
`ifdef FIFO_ECC_ERR_MON_TIMESTAMP_EN
        .first_dbit_ts_o(ts_s),
`endif
        .alarm_o(alarm_s));

    int n_pass = 0, n_total = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] s;
        logic [15:0] d;
        logic        oor;
        int          at;
    } rd_exp_t;
    rd_exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor: pops an expected read response whenever rd_ack_o
    // is presented; an expectation past its due cycle counts as a miss.
    always @(negedge clk) begin
        rd_exp_t e;
        if (q.size() > 0 && cyc > q[0].at) begin
            n_total++;
            $display("FAIL rd_ack_missing: no ack by cycle %0d expected at %0d", cyc, q[0].at);
            void'(q.pop_front());
        end
        if (rd_ack_o) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL rd_ack_unexpected: ack at cycle %0d with nothing pending", cyc);
            end else begin
                e = q.pop_front();
                chk("rd_latency", 64'(cyc), 64'(e.at));
                chk("rd_sbit", 64'(rd_sbit_cnt_o), 64'(e.s));
                chk("rd_dbit", 64'(rd_dbit_cnt_o), 64'(e.d));
                chk("rd_oor", 64'(rd_oor_o), 64'(e.oor));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input int s, input int d, input bit oor);
        rd_exp_t e;
        e.s = 16'(s); e.d = 16'(d); e.oor = oor; e.at = cyc + 2;
        q.push_back(e);
    endtask

    task automatic rd(input int lane, input int s, input int d, input bit oor);
        step();
        rd_req_i = 1'b1; rd_lane_i = 7'(lane); push(s, d, oor);
        step(); rd_req_i = 1'b0;
        step(); step();
    endtask

    task automatic clr_pulse();
        step(); clr_i = 1'b1; step(); clr_i = 1'b0;
    endtask

    task automatic chk_status(input string tag, input bit sa, input bit da, input bit al,
                              input bit fv, input int fl, input int ec);
        chk({tag, ".sbit_any"}, 64'(sbit_any_o), 64'(sa));
        chk({tag, ".dbit_any"}, 64'(dbit_any_o), 64'(da));
        chk({tag, ".alarm"}, 64'(alarm_o), 64'(al));
        chk({tag, ".first_vld"}, 64'(first_dbit_vld_o), 64'(fv));
        chk({tag, ".first_lane"}, 64'(first_dbit_lane_o), 64'(fl));
        chk({tag, ".err_cnt"}, 64'(err_cnt_o), 64'(ec));
    endtask

    initial begin
        // reset state
        repeat (3) step();
        chk_status("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.rd_ack", 64'(rd_ack_o), 64'd0);
        chk("reset.rd_oor", 64'(rd_oor_o), 64'd0);
        rst_i = 1'b0;

        // single double-bit pulse on lane 0
        repeat (600) step();
        dbiterr_i = 48'd1; step(); dbiterr_i = '0;
        chk_status("dbit0_t1", 0, 1, 0, 1, 0, 0);
        step();
        chk("dbit0_t2.alarm", 64'(alarm_o), 64'd1);
        rd(0, 0, 1, 0);

        clr_pulse();
        chk_status("clr1", 0, 0, 0, 0, 0, 0);

        // threshold: 99 pulses below, 100th crosses
        for (int i = 0; i < 99; i++) begin
            sbiterr_i = 48'd1 << 5; step();
        end
        sbiterr_i = '0; step(); step();
        chk("thr99.alarm", 64'(alarm_o), 64'd0);
        chk("thr99.sbit_any", 64'(sbit_any_o), 64'd1);
        sbiterr_i = 48'd1 << 5; step(); sbiterr_i = '0;
        chk("thr100_t1.alarm", 64'(alarm_o), 64'd0);
        step();
        chk("thr100_t2.alarm", 64'(alarm_o), 64'd1);
        rd(5, 100, 0, 0);

        // increment on the RESP-entry edge is not in the returned data
        step();
        rd_req_i = 1'b1; rd_lane_i = 7'd5; sbiterr_i = 48'd1 << 5; push(100, 0, 0);
        step(); rd_req_i = 1'b0; sbiterr_i = '0;
        step(); step();
        rd(5, 101, 0, 0);

        // lowest-index capture, later pulse does not move it
        clr_pulse();
        dbiterr_i = 48'h0000_0000_0410; step(); dbiterr_i = '0;
        chk("cap.first_vld", 64'(first_dbit_vld_o), 64'd1);
        chk("cap.first_lane", 64'(first_dbit_lane_o), 64'd4);
        dbiterr_i = 48'd1 << 2; step(); dbiterr_i = '0; step();
        chk("cap_hold.first_lane", 64'(first_dbit_lane_o), 64'd4);
        rd(4, 0, 1, 0);
        rd(10, 0, 1, 0);
        rd(2, 0, 1, 0);
        rd(5, 0, 0, 0);

        // multi-lane and same-lane sbit+dbit in one cycle
        sbiterr_i = (48'd1 << 9) | (48'd1 << 47) | 48'd1; dbiterr_i = 48'd1 << 9;
        step(); sbiterr_i = '0; dbiterr_i = '0;
        rd(9, 1, 1, 0);
        rd(47, 1, 0, 0);
        rd(0, 1, 0, 0);

        // chain mismatch counter
        err_i = 1'b1; repeat (3) step(); err_i = 1'b0;
        chk("err3.err_cnt", 64'(err_cnt_o), 64'd3);

        // clr wins over same-cycle increment
        step(); clr_i = 1'b1; sbiterr_i = 48'd1 << 7;
        step(); clr_i = 1'b0; sbiterr_i = '0;
        chk_status("clr2", 0, 0, 0, 0, 0, 0);
        step();
        chk("clr2_t2.alarm", 64'(alarm_o), 64'd0);
        rd(7, 0, 0, 0);
        rd(60, 0, 0, 1);
        rd(48, 0, 0, 1);
        rd(47, 0, 0, 0);

        // clr on RESP-entry edge returns zeros
        sbiterr_i = 48'd1 << 11; step(); step(); sbiterr_i = '0;
        rd_req_i = 1'b1; rd_lane_i = 7'd11; clr_i = 1'b1; push(0, 0, 0);
        step(); rd_req_i = 1'b0; clr_i = 1'b0;
        step(); step();

        // clr during RESP does not abort the read
        sbiterr_i = 48'd1 << 11; repeat (3) step(); sbiterr_i = '0;
        rd_req_i = 1'b1; rd_lane_i = 7'd11; push(3, 0, 0);
        step(); rd_req_i = 1'b0; clr_i = 1'b1;
        step(); clr_i = 1'b0;
        step(); step();

        // request while in RESP is ignored (only one ack)
        sbiterr_i = 48'd1 << 12; step(); sbiterr_i = '0;
        rd_req_i = 1'b1; rd_lane_i = 7'd12; push(1, 0, 0);
        step(); rd_lane_i = 7'd60;
        step(); rd_req_i = 1'b0;
        step(); step(); step();

        // reset mid-read: no ack
        rd_req_i = 1'b1; rd_lane_i = 7'd12;
        step(); rd_req_i = 1'b0; rst_i = 1'b1;
        step(); rst_i = 1'b0;
        step(); step(); step();
        chk_status("rst_mid", 0, 0, 0, 0, 0, 0);
        rd(12, 0, 0, 0);

        // narrow counter saturates at 15
        sbiterr_s = 48'd1 << 3; repeat (20) step(); sbiterr_s = '0;
        rd_req_s = 1'b1; rd_lane_s = 7'd3;
        step(); rd_req_s = 1'b0;
        step();
        chk("sat.ack", 64'(ack_s), 64'd1);
        chk("sat.sbit", 64'(scnt_s), 64'd15);
        chk("sat.dbit", 64'(dcnt_s), 64'd0);

`ifdef FIFO_ECC_ERR_MON_TIMESTAMP_EN
        step(); rst_i = 1'b1; step(); step();
        chk("ts.reset", 64'(first_dbit_ts_o), 64'd0);
        rst_i = 1'b0;
        repeat (1000) step();
        dbiterr_i = 48'd1 << 3; step(); dbiterr_i = '0;
        chk("ts.value", 64'(first_dbit_ts_o), 64'd1000);
        chk("ts.lane", 64'(first_dbit_lane_o), 64'd3);
        clr_pulse();
        chk("ts.clr", 64'(first_dbit_ts_o), 64'd0);
`endif

        // drain: bounded wait for outstanding reads
        repeat (8) step();
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL rd_drain: %0d reads still pending", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
